param_digital_lock: RTL and testbench

PARAM_DIGITAL_LOCK -- requirements
Module: param_digital_lock

---
 rtl/param_digital_lock.sv | 241 ++++++++++++++++++++++++
 tb/tb_param_digital_lock.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_digital_lock.sv
// Keypad code lock: two-entry code setup while open, single-entry unlock while locked.
// Latency: locked/error update one cycle after the edge that samples the final digit.
// No backpressure: keys are edge-qualified by an armed flag; optional lockout via DIGITAL_LOCK_LOCKOUT_EN.
module param_digital_lock #(
  parameter int KEY_WIDTH       = 4,
  parameter int PASSCODE_LENGTH = 4,
  parameter logic [KEY_WIDTH*PASSCODE_LENGTH-1:0] RESET_CODE = 16'h8148,
  parameter int TIMEOUT         = 500000000,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 1500000000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 key,
  output logic                                 locked,
  output logic                                 error,
  output logic                                 lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    attempts_left,
  output logic [$clog2(PASSCODE_LENGTH+1)-1:0] entry_count
);

  localparam int CODE_W = KEY_WIDTH * PASSCODE_LENGTH;
  localparam int CNT_W  = $clog2(PASSCODE_LENGTH + 1);
  localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OPEN_ENTRY1  = 3'd0;
  localparam logic [2:0] OPEN_ENTRY2  = 3'd1;
  localparam logic [2:0] OPEN_CHECK   = 3'd2;
  localparam logic [2:0] LOCKED_ENTRY = 3'd3;
  localparam logic [2:0] LOCKED_CHECK = 3'd4;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
  localparam logic [2:0] LOCKOUT      = 3'd5;
  localparam int         LCK_W        = $clog2(LOCKOUT_CYCLES + 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [CODE_W-1:0] entry_q, entry_d;
  logic [CODE_W-1:0] first_q, first_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              armed_q, armed_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
  logic [ATT_W-1:0]  attempts_q, attempts_d;
  logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              lockout_q, lockout_d;
`endif

  logic              in_entry;
  logic              key_nz;
  logic              accept;
  logic              last_digit;
  logic              timer_run;
  logic              timer_exp;
  logic [CODE_W-1:0] shifted;

  assign in_entry   = (state_q == OPEN_ENTRY1) || (state_q == OPEN_ENTRY2) ||
                      (state_q == LOCKED_ENTRY);
  assign key_nz     = |key;
  assign accept     = in_entry && key_nz && armed_q;
  assign last_digit = (cnt_q == CNT_W'(PASSCODE_LENGTH - 1));
  // Idle timer only matters once an entry is under way (OPEN_ENTRY2 always is).
  assign timer_run  = in_entry && !accept && ((cnt_q != '0) || (state_q == OPEN_ENTRY2));
  assign timer_exp  = timer_run && (timer_q == TMR_W'(TIMEOUT - 1));
  assign shifted    = {entry_q[CODE_W-KEY_WIDTH-1:0], key};

  // Next-state logic: digit capture, code compare, timeout and lockout handling.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    first_d  = first_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    armed_d  = armed_q;
    locked_d = locked_q;
    error_d  = error_q;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
    attempts_d = attempts_q;
    lock_cnt_d = lock_cnt_q;
    lockout_d  = lockout_q;
`endif

    // Armed tracks key release in every state so a held key never repeats.
    if (!key_nz) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end

    case (state_q)
      OPEN_ENTRY1, OPEN_ENTRY2, LOCKED_ENTRY: begin
        if (accept) begin
          entry_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          timer_d = '0;
          error_d = 1'b0;
          if (last_digit) begin
            if (state_q == OPEN_ENTRY1) begin
              first_d = shifted;
              entry_d = '0;
              cnt_d   = '0;
              state_d = OPEN_ENTRY2;
            end else if (state_q == OPEN_ENTRY2) begin
              state_d = OPEN_CHECK;
            end else begin
              state_d = LOCKED_CHECK;
            end
          end
        end else if (timer_exp) begin
          // Abandoned entry: flag it but never count it as a failed attempt.
          error_d = 1'b1;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = locked_q ? LOCKED_ENTRY : OPEN_ENTRY1;
        end else if (timer_run) begin
          timer_d = timer_q + TMR_W'(1);
        end else begin
          timer_d = '0;
        end
      end

      OPEN_CHECK: begin
        if (entry_q == first_q) begin
          code_d   = entry_q;
          locked_d = 1'b1;
          state_d  = LOCKED_ENTRY;
        end else begin
          error_d  = 1'b1;
          state_d  = OPEN_ENTRY1;
        end
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end

      LOCKED_CHECK: begin
        if (entry_q == code_q) begin
          locked_d = 1'b0;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
          attempts_d = ATT_W'(MAX_ATTEMPTS);
`endif
          state_d  = OPEN_ENTRY1;
        end else begin
          error_d  = 1'b1;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
          attempts_d = attempts_q - ATT_W'(1);
          if (attempts_q == ATT_W'(1)) begin
            lockout_d  = 1'b1;
            lock_cnt_d = '0;
            state_d    = LOCKOUT;
          end else begin
            state_d    = LOCKED_ENTRY;
          end
`else
          state_d  = LOCKED_ENTRY;
`endif
        end
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end

`ifdef DIGITAL_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        // Keypad ignored; lock stays closed until the penalty window elapses.
        if (lock_cnt_q == LCK_W'(LOCKOUT_CYCLES - 1)) begin
          lockout_d  = 1'b0;
          lock_cnt_d = '0;
          attempts_d = ATT_W'(MAX_ATTEMPTS);
          state_d    = LOCKED_ENTRY;
        end else begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
      end
`endif

      default: begin
        state_d = OPEN_ENTRY1;
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset back to the open, factory-code condition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OPEN_ENTRY1;
      entry_q  <= '0;
      first_q  <= '0;
      code_q   <= RESET_CODE;
      cnt_q    <= '0;
      timer_q  <= '0;
      armed_q  <= 1'b1;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
      attempts_q <= ATT_W'(MAX_ATTEMPTS);
      lock_cnt_q <= '0;
      lockout_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      first_q  <= first_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
      locked_q <= locked_d;
      error_q  <= error_d;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
      attempts_q <= attempts_d;
      lock_cnt_q <= lock_cnt_d;
      lockout_q  <= lockout_d;
`endif
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign entry_count = cnt_q;
`ifdef DIGITAL_LOCK_LOCKOUT_EN
  assign lockout       = lockout_q;
  assign attempts_left = attempts_q;
`else
  // Without lockout retries are unlimited, so the attempt count never moves.
  assign lockout       = 1'b0;
  assign attempts_left = ATT_W'(MAX_ATTEMPTS);
  // Keeps the lockout duration referenced in builds that have no lockout timer.
  logic [31:0] unused_lockout_cycles;
  assign unused_lockout_cycles = LOCKOUT_CYCLES;
`endif

endmodule

// File: tb/tb_param_digital_lock.sv
// Directed bench for param_digital_lock: table of per-cycle vectors plus hand sequences.
module tb_param_digital_lock;

  logic       clock;
  logic       reset;
  logic [3:0] key;
  logic       locked;
  logic       error;
  logic       lockout;
  logic [1:0] attempts_left;
  logic [2:0] entry_count;

  int checks   = 0;
  int failures = 0;

  param_digital_lock #(
    .KEY_WIDTH      (4),
    .PASSCODE_LENGTH(4),
    .RESET_CODE     (16'h8148),
    .TIMEOUT        (10),
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .locked       (locked),
    .error        (error),
    .lockout      (lockout),
    .attempts_left(attempts_left),
    .entry_count  (entry_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] k;
    logic       l;
    logic       e;
    logic [2:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] k, input logic l, input logic e, input logic [2:0] c);
    vec_t v;
    v.k = k; v.l = l; v.e = e; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    key = d;
    tick();
    key = 4'd0;
    tick();
  endtask

  task automatic press4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    key   = 4'd0;
    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_attempts", attempts_left, 3);
    chk("rst_count", entry_count, 0);
    reset = 1'b0;

    // Set code 1481 twice, fail once with 1482 while locked, then unlock with 1481.
    add(1,0,0,1); add(0,0,0,1); add(4,0,0,2); add(0,0,0,2);
    add(8,0,0,3); add(0,0,0,3); add(1,0,0,0); add(0,0,0,0);
    add(1,0,0,1); add(0,0,0,1); add(4,0,0,2); add(0,0,0,2);
    add(8,0,0,3); add(0,0,0,3); add(1,0,0,4); add(0,1,0,0);
    add(1,1,0,1); add(0,1,0,1); add(4,1,0,2); add(0,1,0,2);
    add(8,1,0,3); add(0,1,0,3); add(2,1,0,4); add(0,1,1,0);
    add(1,1,0,1); add(0,1,0,1); add(4,1,0,2); add(0,1,0,2);
    add(8,1,0,3); add(0,1,0,3); add(1,1,0,4); add(0,0,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      key = tbl[i].k;
      tick();
      chk($sformatf("vec%0d_locked", i), locked, tbl[i].l);
      chk($sformatf("vec%0d_error", i), error, tbl[i].e);
      chk($sformatf("vec%0d_count", i), entry_count, tbl[i].c);
    end

    // Mismatched confirmation while open.
    press4(1, 2, 3, 4);
    press4(1, 2, 3, 5);
    chk("mis_error", error, 1);
    chk("mis_locked", locked, 0);
    chk("mis_count", entry_count, 0);
    key = 4'd3;
    tick();
    chk("mis_next_error", error, 0);
    chk("mis_next_count", entry_count, 1);

    // Idle timeout: nine idle cycles keep the entry, the tenth expires it.
    key = 4'd0;
    repeat (9) tick();
    chk("tmo_pre_count", entry_count, 1);
    chk("tmo_pre_error", error, 0);
    tick();
    chk("tmo_error", error, 1);
    chk("tmo_count", entry_count, 0);
    chk("tmo_locked", locked, 0);

    // A digit on the expiry cycle wins over the timeout.
    key = 4'd3;
    tick();
    key = 4'd0;
    repeat (9) tick();
    key = 4'd5;
    tick();
    chk("tmo_race_count", entry_count, 2);
    chk("tmo_race_error", error, 0);
    key = 4'd0;
    repeat (12) tick();
    chk("tmo_clear_count", entry_count, 0);
    chk("tmo_clear_error", error, 1);

    // Lock with 1234, unlock, then a held key counts once.
    press4(1, 2, 3, 4);
    press4(1, 2, 3, 4);
    chk("set1234_locked", locked, 1);
    press4(1, 2, 3, 4);
    chk("unlock_locked", locked, 0);
    chk("unlock_attempts", attempts_left, 3);
    key = 4'd1;
    repeat (10) tick();
    key = 4'd0;
    chk("held_count", entry_count, 1);
    repeat (12) tick();
    chk("held_clear_count", entry_count, 0);

    // Final digit held across the check is not taken again afterwards.
    press4(1, 2, 3, 4);
    press(1); press(2); press(3);
    key = 4'd4;
    repeat (5) tick();
    chk("holdchk_locked", locked, 1);
    chk("holdchk_count", entry_count, 0);
    key = 4'd0;
    tick();

    // Three wrong unlock attempts.
    for (int n = 0; n < 3; n++) begin
      press4(9, 9, 9, 9);
      chk($sformatf("wrong%0d_error", n), error, 1);
      chk($sformatf("wrong%0d_locked", n), locked, 1);
`ifdef DIGITAL_LOCK_LOCKOUT_EN
      chk($sformatf("wrong%0d_attempts", n), attempts_left, 2 - n);
`else
      chk($sformatf("wrong%0d_attempts", n), attempts_left, 3);
      chk($sformatf("wrong%0d_lockout", n), lockout, 0);
`endif
    end
`ifdef DIGITAL_LOCK_LOCKOUT_EN
    chk("lko_enter", lockout, 1);
    for (int i = 0; i < 19; i++) begin
      key = (i < 16 && (i % 2) == 0) ? 4'd5 : 4'd0;
      tick();
      chk($sformatf("lko%0d_lockout", i), lockout, 1);
      chk($sformatf("lko%0d_count", i), entry_count, 0);
      chk($sformatf("lko%0d_locked", i), locked, 1);
    end
    key = 4'd0;
    tick();
    chk("lko_exit_lockout", lockout, 0);
    chk("lko_exit_attempts", attempts_left, 3);
    chk("lko_exit_locked", locked, 1);
`endif
    press4(1, 2, 3, 4);
    chk("retry_locked", locked, 0);
    chk("retry_attempts", attempts_left, 3);

    // Reset in the middle of a locked entry.
    press4(1, 2, 3, 4);
    press4(1, 2, 3, 4);
    press(5); press(6);
    chk("mid_locked", locked, 1);
    chk("mid_count", entry_count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_locked", locked, 0);
    chk("rst2_count", entry_count, 0);
    chk("rst2_error", error, 0);
    chk("rst2_lockout", lockout, 0);
    chk("rst2_attempts", attempts_left, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
